cpu0_mem_arbiter: RTL and testbench
===================================

// Module: cpu0_mem_arbiter
// PURPOSE
//  Shares the single memory0 port (m_en/m_rw/m_size/mar/mdr/dbus) between NREQ bus masters:
//   requester 0 is the cpu0 core, 1..NREQ-1 are DMA/IO engines.
//  Each access is one transaction: arbitrate, run it, then acknowledge; read data returns on rdata.
//  Addresses outside memory (other than IO_ADDR) are rejected with err and never reach memory0.
// PARAMETERS
//  NREQ      2        number of requesters, 2..4
//  MEMSIZE   'h80000  memory bytes; legal addr is 0..MEMSIZE-4
//  IO_ADDR   'h80000  IO-mapped word; legal, passed through to the bus, no err
//  WAIT_CYC  0        extra ACCESS cycles for slower memory, 0..15
// PORTS
//  clock      in   1         system clock
//  reset      in   1         synchronous, active-high reset
//  req        in   NREQ      request per master; held high until its ack
//  req_rw     in   NREQ      1=read, 0=write
//  req_size   in   2*NREQ    size code per master, slice [2i+1:2i]
//  req_addr   in   32*NREQ   byte address per master
//  req_wdata  in   32*NREQ   write data per master, right-aligned
//  gnt        out  NREQ      one-hot owner, from the start of ACCESS through COMPLETE
//  ack        out  NREQ      1-cycle pulse to the owner when its transaction completes
//  err        out  NREQ      1-cycle pulse with ack for an illegal address
//  rdata      out  32        read data, valid in the cycle ack is high
//  m_en       out  1         memory enable
//  m_rw       out  1         1=read, 0=write
//  m_size     out  2         BYTE=00, INT16=01, INT24=10, INT32=11
//  mar        out  32        memory address
//  mdr        out  32        memory write data
//  dbus       in   32        memory read data, combinational from memory0
// BEHAVIOUR
//  - Reset: state=IDLE, gnt=0, ack=0, err=0, rdata=0, m_en=0, m_rw=1, m_size=11, mar=0, mdr=0,
//    rr_last=NREQ-1 (requester 0 wins first).
//  - Reset mid-transaction: m_en goes low at the next edge, no ack, and the transaction is lost.
//  - IDLE: if any req is high, a winner is picked by round-robin starting at rr_last+1.
//    rw, size, addr and wdata of the winner are latched; gnt goes high; state goes to ACCESS.
//  - ACCESS: lasts 1+WAIT_CYC cycles, counted by wcnt.
//    Legal address: m_en=1; m_rw, m_size, mar, mdr come from the latched values.
//    Illegal address: m_en stays 0.
//    On the last ACCESS edge: rdata<=dbus for a legal read, else rdata<=0. State goes to COMPLETE.
//  - COMPLETE: m_en=0; ack[owner]=1; err[owner]=illegal; rr_last<=owner.
//    State goes to IDLE at the next edge and gnt clears there.
//  - Latency: req sampled in IDLE at cycle 0; m_en high in cycles 1..1+WAIT_CYC; ack at 2+WAIT_CYC.
//    Peak throughput: one transaction per 3+WAIT_CYC cycles.
//  - A req still high in the IDLE after its ack is a new request.
//  - A req dropped mid-transaction still completes and is acked.
//  - A req raised while busy waits; no new pick happens outside IDLE.
//  - Requests arriving together are resolved only by the round-robin order, so no master starves.
//  - mar, mdr, m_size hold their last values while m_en=0.
//  - Latched addr/data are 32-bit unsigned. Legal means addr<=MEMSIZE-4 or addr==IO_ADDR.
// CONFIGURATION
//  ARB_FIXED_PRIO_EN
//    defined:   fixed priority, lowest index wins (cpu0 always first); rr_last is unused.
//    undefined: round-robin, as above.
// STRUCTURE
//  - Package cpu0_mem_pkg holds:
//      size codes BYTE/INT16/INT24/INT32
//      MEMSIZE and IOADDR defaults
//      arbiter state encoding IDLE/ACCESS/COMPLETE
//  - One sub-module, mem_rr_picker: combinational one-hot pick from req and rr_last
//    (fixed-priority when ARB_FIXED_PRIO_EN is defined).
//  - FSM, wait counter and latches stay in cpu0_mem_arbiter.
// TESTING
//  1. Read on requester 0: req=01, addr=0x100, mem word=0x11223344, size=11.
//     -> cycle 1: m_en=1, m_rw=1, mar=0x100.
//     -> cycle 2: ack=01, rdata=0x11223344.
//  2. req=11 held from reset, NREQ=2, WAIT_CYC=0.
//     -> gnt order 01,10,01,10; one ack every 3 cycles; err never high.
//  3. Byte write on requester 1: addr=0x200, wdata=0x000000AB, size=00.
//     -> m_rw=0, mdr=0xAB, m_size=00; afterwards m[0x200]=AB.
//  4. Illegal read: addr=0x90000.
//     -> m_en stays 0; cycle 2: ack=01, err=01, rdata=0.
//     Same test with addr=0x80000 -> m_en=1 and err=0.
//  5. reset pulsed during ACCESS.
//     -> next cycle: m_en=0, gnt=0, no ack; first grant after reset goes to requester 0.
//  6. WAIT_CYC=2 -> m_en high 3 cycles, ack at cycle 4.
//     With ARB_FIXED_PRIO_EN and req=11 held -> requester 0 wins every arbitration.

Source files
------------

// File: rtl/cpu0_mem_pkg.sv
// Shared types and defaults for the cpu0 memory0 arbiter: size codes,
// memory map defaults and the arbiter state encoding.
package cpu0_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_INT16 = 2'b01,
    SZ_INT24 = 2'b10,
    SZ_INT32 = 2'b11
  } size_e;

  localparam logic [31:0] MEMSIZE_DEF = 32'h0008_0000;
  localparam logic [31:0] IOADDR_DEF  = 32'h0008_0000;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ACCESS   = 2'b01,
    COMPLETE = 2'b10
  } arb_state_e;

endpackage

// File: rtl/cpu0_mem_arbiter_if.sv
// Requester and memory0 bus bundle for cpu0_mem_arbiter; the arbiter uses the
// slave view, the requesters/memory side uses the master view.
interface cpu0_mem_arbiter_if
  import cpu0_mem_pkg::*;
#(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      req_rw;
  logic [2*NREQ-1:0]    req_size;
  logic [32*NREQ-1:0]   req_addr;
  logic [32*NREQ-1:0]   req_wdata;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      ack;
  logic [NREQ-1:0]      err;
  logic [31:0]          rdata;
  logic                 m_en;
  logic                 m_rw;
  size_e                m_size;
  logic [31:0]          mar;
  logic [31:0]          mdr;
  logic [31:0]          dbus;

  modport slave (
    input  req, req_rw, req_size, req_addr, req_wdata, dbus,
    output gnt, ack, err, rdata, m_en, m_rw, m_size, mar, mdr
  );

  modport master (
    output req, req_rw, req_size, req_addr, req_wdata, dbus,
    input  gnt, ack, err, rdata, m_en, m_rw, m_size, mar, mdr
  );
endinterface

// File: rtl/mem_rr_picker.sv
// Combinational one-hot requester pick, round-robin after rr_last;
// ARB_FIXED_PRIO_EN switches to fixed priority (lowest index wins).
module mem_rr_picker #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] rr_last,
  output logic [NREQ-1:0]  pick,
  output logic [IDX_W-1:0] pick_idx
);

`ifdef ARB_FIXED_PRIO_EN
  logic unused_rr_last;
  assign unused_rr_last = ^rr_last;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        pick     = '0;
        pick[i]  = 1'b1;
        pick_idx = IDX_W'(i);
      end
    end
  end
`else
  logic found;

  // Search order rr_last+1, rr_last+2, ... wrapping, so the last owner goes last.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req[i] && (((int'(rr_last) + k) % NREQ) == i)) begin
          found    = 1'b1;
          pick[i]  = 1'b1;
          pick_idx = IDX_W'(i);
        end
      end
    end
  end
`endif

endmodule

// File: rtl/cpu0_mem_arbiter.sv
// Arbitrates NREQ masters onto the single memory0 port, one transaction at a time.
// Optional macro ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module cpu0_mem_arbiter
  import cpu0_mem_pkg::*;
#(
  parameter int          NREQ     = 2,
  parameter logic [31:0] MEMSIZE  = MEMSIZE_DEF,
  parameter logic [31:0] IO_ADDR  = IOADDR_DEF,
  parameter int          WAIT_CYC = 0
) (
  input  logic              clock,
  input  logic              reset,
  cpu0_mem_arbiter_if.slave bus
);

  localparam int          IDX_W = $clog2(NREQ);
  localparam logic [3:0]  WLAST = 4'(WAIT_CYC);

  arb_state_e       state, state_n;
  logic [3:0]       wcnt;
  logic [IDX_W-1:0] rr_last, owner, pick_idx;
  logic [NREQ-1:0]  pick, gnt_q;
  logic             lat_rw, lat_legal;
  logic [31:0]      rdata_q, mar_q, mdr_q;
  logic             m_rw_q;
  size_e            m_size_q;
  logic [31:0]      win_addr, win_wdata;
  logic             win_rw, win_legal, last_acc;
  size_e            win_size;

  function automatic logic addr_legal(input logic [31:0] a);
    return (a <= (MEMSIZE - 32'd4)) || (a == IO_ADDR);
  endfunction

  mem_rr_picker #(.NREQ(NREQ), .IDX_W(IDX_W)) u_picker (
    .req      (bus.req),
    .rr_last  (rr_last),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  always_comb begin
    win_addr  = '0;
    win_wdata = '0;
    win_rw    = 1'b1;
    win_size  = SZ_INT32;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) begin
        win_addr  = bus.req_addr[32*i +: 32];
        win_wdata = bus.req_wdata[32*i +: 32];
        win_rw    = bus.req_rw[i];
        win_size  = size_e'(bus.req_size[2*i +: 2]);
      end
    end
  end

  assign win_legal = addr_legal(win_addr);
  assign last_acc  = (state == ACCESS) && (wcnt == WLAST);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (|bus.req) state_n = ACCESS;
      ACCESS:   if (last_acc) state_n = COMPLETE;
      COMPLETE: state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Grant latch on the IDLE edge, wait count in ACCESS, release in COMPLETE.
  always_ff @(posedge clock) begin
    if (reset) begin
      gnt_q     <= '0;
      owner     <= '0;
      rr_last   <= IDX_W'(NREQ - 1);
      wcnt      <= '0;
      lat_rw    <= 1'b1;
      lat_legal <= 1'b0;
      rdata_q   <= '0;
      m_rw_q    <= 1'b1;
      m_size_q  <= SZ_INT32;
      mar_q     <= '0;
      mdr_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            gnt_q     <= pick;
            owner     <= pick_idx;
            lat_rw    <= win_rw;
            lat_legal <= win_legal;
            wcnt      <= '0;
            // Illegal accesses never touch the memory bus, so it keeps its last values.
            if (win_legal) begin
              m_rw_q   <= win_rw;
              m_size_q <= win_size;
              mar_q    <= win_addr;
              mdr_q    <= win_wdata;
            end
          end
        end
        ACCESS: begin
          wcnt <= wcnt + 4'd1;
          if (last_acc) rdata_q <= (lat_legal && lat_rw) ? bus.dbus : 32'd0;
        end
        COMPLETE: begin
          rr_last <= owner;
          gnt_q   <= '0;
        end
        default: gnt_q <= '0;
      endcase
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.ack    = (state == COMPLETE) ? gnt_q : '0;
  assign bus.err    = ((state == COMPLETE) && !lat_legal) ? gnt_q : '0;
  assign bus.rdata  = rdata_q;
  assign bus.m_en   = (state == ACCESS) && lat_legal;
  assign bus.m_rw   = m_rw_q;
  assign bus.m_size = m_size_q;
  assign bus.mar    = mar_q;
  assign bus.mdr    = mdr_q;

endmodule

// File: tb/tb_cpu0_mem_arbiter.sv
// Directed bench for cpu0_mem_arbiter: a zero-wait instance with a byte memory
// model and a WAIT_CYC=2 instance for the slow-memory timing.
module tb_cpu0_mem_arbiter;
  import cpu0_mem_pkg::*;

`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   passed = 0;
  int   fails  = 0;

  always #5 clock = ~clock;

  cpu0_mem_arbiter_if #(.NREQ(2)) bus0 ();
  cpu0_mem_arbiter_if #(.NREQ(2)) bus1 ();

  cpu0_mem_arbiter #(.NREQ(2), .WAIT_CYC(0)) dut0 (.clock(clock), .reset(reset), .bus(bus0));
  cpu0_mem_arbiter #(.NREQ(2), .WAIT_CYC(2)) dut1 (.clock(clock), .reset(reset), .bus(bus1));

  // Byte-addressed memory model behind dut0; word 0x100 is preset to 0x11223344.
  logic [7:0]  mem [4096];
  logic [11:0] ma;

  always_comb begin
    ma = bus0.mar[11:0];
    if (bus0.mar == 32'h100) bus0.dbus = 32'h1122_3344;
    else bus0.dbus = {mem[ma + 12'd3], mem[ma + 12'd2], mem[ma + 12'd1], mem[ma]};
  end

  always @(posedge clock) begin
    if (bus0.m_en && !bus0.m_rw)
      for (int b = 0; b < 4; b++)
        if (b <= int'(bus0.m_size)) mem[ma + 12'(b)] <= bus0.mdr[8*b +: 8];
  end

  assign bus1.dbus = 32'hCAFE_F00D;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_g;
    reset = 1'b1;
    bus0.req = '0; bus0.req_rw = '1; bus0.req_size = '1; bus0.req_addr = '0; bus0.req_wdata = '0;
    bus1.req = '0; bus1.req_rw = '1; bus1.req_size = '1; bus1.req_addr = '0; bus1.req_wdata = '0;
    tick(); tick();

    check("rst_gnt",    32'(bus0.gnt),    32'h0);
    check("rst_ack",    32'(bus0.ack),    32'h0);
    check("rst_err",    32'(bus0.err),    32'h0);
    check("rst_rdata",  bus0.rdata,       32'h0);
    check("rst_m_en",   32'(bus0.m_en),   32'h0);
    check("rst_m_rw",   32'(bus0.m_rw),   32'h1);
    check("rst_m_size", 32'(bus0.m_size), 32'h3);
    check("rst_mar",    bus0.mar,         32'h0);
    check("rst_mdr",    bus0.mdr,         32'h0);
    reset = 1'b0;

    // Word read on requester 0
    bus0.req_rw[0] = 1'b1; bus0.req_size[1:0] = 2'b11; bus0.req_addr[31:0] = 32'h100;
    bus0.req = 2'b01;
    tick();
    check("t1_m_en", 32'(bus0.m_en), 32'h1);
    check("t1_m_rw", 32'(bus0.m_rw), 32'h1);
    check("t1_mar",  bus0.mar,       32'h100);
    check("t1_gnt",  32'(bus0.gnt),  32'h1);
    tick();
    check("t1_ack",   32'(bus0.ack), 32'h1);
    check("t1_err",   32'(bus0.err), 32'h0);
    check("t1_rdata", bus0.rdata,    32'h1122_3344);
    bus0.req = 2'b00;
    tick();
    check("t1_idle_ack", 32'(bus0.ack), 32'h0);
    check("t1_idle_gnt", 32'(bus0.gnt), 32'h0);

    // Byte write on requester 1
    bus0.req_rw[1] = 1'b0; bus0.req_size[3:2] = 2'b00;
    bus0.req_addr[63:32] = 32'h200; bus0.req_wdata[63:32] = 32'h0000_00AB;
    bus0.req = 2'b10;
    tick();
    check("t3_gnt",    32'(bus0.gnt),    32'h2);
    check("t3_m_en",   32'(bus0.m_en),   32'h1);
    check("t3_m_rw",   32'(bus0.m_rw),   32'h0);
    check("t3_mdr",    bus0.mdr,         32'hAB);
    check("t3_m_size", 32'(bus0.m_size), 32'h0);
    check("t3_mar",    bus0.mar,         32'h200);
    tick();
    check("t3_ack", 32'(bus0.ack), 32'h2);
    check("t3_err", 32'(bus0.err), 32'h0);
    bus0.req = 2'b00;
    tick();
    check("t3_mem200", 32'(mem[12'h200]), 32'hAB);
    check("t3_mem201", 32'(mem[12'h201]), 32'h0);

    // Out-of-range read: never reaches memory, errors on ack
    bus0.req_rw[0] = 1'b1; bus0.req_addr[31:0] = 32'h9_0000;
    bus0.req = 2'b01;
    tick();
    check("t4_gnt",      32'(bus0.gnt),  32'h1);
    check("t4_m_en",     32'(bus0.m_en), 32'h0);
    check("t4_mar_hold", bus0.mar,       32'h200);
    tick();
    check("t4_ack",   32'(bus0.ack), 32'h1);
    check("t4_err",   32'(bus0.err), 32'h1);
    check("t4_rdata", bus0.rdata,    32'h0);
    bus0.req = 2'b00;
    tick();

    // IO-mapped word is legal
    bus0.req_addr[31:0] = 32'h8_0000;
    bus0.req = 2'b01;
    tick();
    check("t4io_m_en", 32'(bus0.m_en), 32'h1);
    check("t4io_mar",  bus0.mar,       32'h8_0000);
    tick();
    check("t4io_ack", 32'(bus0.ack), 32'h1);
    check("t4io_err", 32'(bus0.err), 32'h0);
    bus0.req = 2'b00;
    tick();

    // Both requesters held from reset
    bus0.req_rw = 2'b11; bus0.req_addr = {32'h20, 32'h10};
    reset = 1'b1; bus0.req = 2'b11;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_g = (FIXED || (k % 2 == 0)) ? 2'b01 : 2'b10;
      tick();
      check("t2_gnt", 32'(bus0.gnt), 32'(exp_g));
      check("t2_ack_busy", 32'(bus0.ack), 32'h0);
      tick();
      check("t2_ack", 32'(bus0.ack), 32'(exp_g));
      check("t2_err", 32'(bus0.err), 32'h0);
      tick();
      check("t2_ack_idle", 32'(bus0.ack), 32'h0);
    end

    // Reset in the middle of an ACCESS
    tick();
    check("t5_gnt_a", 32'(bus0.gnt), 32'h1);
    tick(); tick(); tick();
    exp_g = FIXED ? 2'b01 : 2'b10;
    check("t5_gnt_b", 32'(bus0.gnt), 32'(exp_g));
    reset = 1'b1;
    tick();
    check("t5_m_en", 32'(bus0.m_en), 32'h0);
    check("t5_gnt",  32'(bus0.gnt),  32'h0);
    check("t5_ack",  32'(bus0.ack),  32'h0);
    reset = 1'b0;
    tick();
    check("t5_first_gnt", 32'(bus0.gnt), 32'h1);
    bus0.req = 2'b00;
    tick();
    check("t5_ack_after", 32'(bus0.ack), 32'h1);
    tick();

    // Slow memory: WAIT_CYC=2
    bus1.req_rw[0] = 1'b1; bus1.req_addr[31:0] = 32'h40;
    bus1.req = 2'b01;
    tick();
    check("t6_m_en_c1", 32'(bus1.m_en), 32'h1);
    tick();
    check("t6_m_en_c2", 32'(bus1.m_en), 32'h1);
    tick();
    check("t6_m_en_c3", 32'(bus1.m_en), 32'h1);
    check("t6_ack_c3",  32'(bus1.ack),  32'h0);
    tick();
    check("t6_m_en_c4", 32'(bus1.m_en), 32'h0);
    check("t6_ack_c4",  32'(bus1.ack),  32'h1);
    check("t6_rdata",   bus1.rdata,     32'hCAFE_F00D);
    bus1.req = 2'b00;
    tick();
    check("t6_ack_c5", 32'(bus1.ack), 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
